// File: rtl/PARAMS_BN254_d0.sv
// Shared parameters and types for the BN254 pre-adder datapath.
package PARAMS_BN254_d0;

    localparam int N_THREADS = 4;
    localparam int NUM_LIMBS = 3;
    localparam int LIMB_W    = 18;

    typedef logic [NUM_LIMBS-1:0][LIMB_W-1:0] redundant_poly_L3;

    localparam logic [1:0] MODE_BUBBLE = 2'b00;
    localparam logic [1:0] MODE_ADD    = 2'b01;
    localparam logic [1:0] MODE_SUB    = 2'b10;

    // One buffered operand pair as it travels through the per-thread queues.
    typedef struct packed {
        redundant_poly_L3 x;
        redundant_poly_L3 y;
        logic [1:0]       mode;
        logic             last;
    } preadd_op_t;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_ADD) || (mode == MODE_SUB);
    endfunction

endpackage

// File: rtl/preadd_thread_fifo.sv
// Per-thread circular operand buffer with occupancy count; head is read combinationally.
module preadd_thread_fifo
    import PARAMS_BN254_d0::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  preadd_op_t                 wdata,
    input  logic                       pop,
    output preadd_op_t                 head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    preadd_op_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/preadd_issue.sv
// Round-robin operand issuer: buffers per-thread chains and releases each
// complete chain one entry per turn of its thread, with a delayed mode stream.
module preadd_issue
    import PARAMS_BN254_d0::*;
#(
    parameter int DEPTH = 8,
    parameter int TID_W = $clog2(N_THREADS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TID_W-1:0] in_tid,
    input  redundant_poly_L3 in_x,
    input  redundant_poly_L3 in_y,
    input  logic [1:0]       in_mode,
    input  logic             in_last,
    output redundant_poly_L3 x_o,
    output redundant_poly_L3 y_o,
    output logic             out_valid,
    output logic [TID_W-1:0] out_tid,
    output logic [1:0]       mode_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [TID_W-1:0]     slot;
    logic [CNT_W-1:0]     count [N_THREADS];
    logic [CNT_W-1:0]     grp   [N_THREADS];
    preadd_op_t           head  [N_THREADS];
    logic [N_THREADS-1:0] push;
    logic [N_THREADS-1:0] pop;
    logic                 accept;
    logic                 in_legal;
    logic                 issue;
    logic                 overflow;
    preadd_op_t           in_op;
    preadd_op_t           issue_op;
    logic [1:0]           cur_mode;
    logic [1:0]           mode_sr [N_THREADS];

    assign in_op    = '{x: in_x, y: in_y, mode: in_mode, last: in_last};
    assign in_legal = mode_legal(in_mode);
    assign accept   = in_valid && in_ready;
    assign issue    = (grp[slot] != '0);
    assign issue_op = head[slot];
    assign mode_o   = mode_sr[N_THREADS-1];

    // Ready depends only on registered occupancy, never on this cycle's issue.
    always_comb begin
        in_ready = 1'b0;
        if (32'(in_tid) < N_THREADS) begin
            in_ready = (count[in_tid] < CNT_W'(DEPTH));
        end
    end

    // Illegal-mode entries are handshaken but never written, so they vanish here.
    always_comb begin
        push     = '0;
        pop      = '0;
        overflow = 1'b0;
        for (int t = 0; t < N_THREADS; t++) begin
            push[t] = accept && in_legal && (in_tid == TID_W'(t));
            pop[t]  = issue && (slot == TID_W'(t));
            if ((count[t] == CNT_W'(DEPTH)) && (grp[t] == '0)) begin
                overflow = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_THREADS; g++) begin : g_thread
        preadd_thread_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .wdata (in_op),
            .pop   (pop[g]),
            .head  (head[g]),
            .count (count[g])
        );
    end

    // Free-running slot owner, visiting every thread once per round.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (slot == TID_W'(N_THREADS - 1)) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // Complete-chain counters gate issue so a chain never streams with gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) grp[t] <= '0;
        end else begin
            for (int t = 0; t < N_THREADS; t++) begin
                if ((push[t] && in_last) && !(pop[t] && head[t].last)) begin
                    grp[t] <= grp[t] + 1'b1;
                end else if (!(push[t] && in_last) && (pop[t] && head[t].last)) begin
                    grp[t] <= grp[t] - 1'b1;
                end
            end
        end
    end

    // Registered issue stage; bubbles drive zeros and record a null mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_o       <= '0;
            y_o       <= '0;
            out_valid <= 1'b0;
            out_tid   <= '0;
            cur_mode  <= MODE_BUBBLE;
        end else begin
            out_tid <= slot;
            if (issue) begin
                x_o       <= issue_op.x;
                y_o       <= issue_op.y;
                out_valid <= 1'b1;
                cur_mode  <= issue_op.mode;
            end else begin
                x_o       <= '0;
                y_o       <= '0;
                out_valid <= 1'b0;
                cur_mode  <= MODE_BUBBLE;
            end
        end
    end

    // Delay the presented mode by one round to line up with the pre-adder mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) mode_sr[i] <= MODE_BUBBLE;
        end else begin
            mode_sr[0] <= cur_mode;
            for (int i = 1; i < N_THREADS; i++) mode_sr[i] <= mode_sr[i-1];
        end
    end

    // Sticky error for dropped illegal modes or a full queue that can never drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if ((accept && !in_legal) || overflow) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_preadd_issue.sv
// Scoreboard bench for preadd_issue: completed chains are queued per thread,
// and a negedge monitor checks every slot against them.
module tb_preadd_issue;
    import PARAMS_BN254_d0::*;

    localparam int N      = N_THREADS;
    localparam int DEPTH  = 8;
    localparam int TID_W  = $clog2(N);
    localparam int POLY_W = $bits(redundant_poly_L3);

    typedef struct {
        redundant_poly_L3 x;
        redundant_poly_L3 y;
        logic [1:0]       mode;
        bit               first;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [TID_W-1:0] in_tid;
    redundant_poly_L3 in_x;
    redundant_poly_L3 in_y;
    logic [1:0]       in_mode;
    logic             in_last;
    redundant_poly_L3 x_o;
    redundant_poly_L3 y_o;
    logic             out_valid;
    logic [TID_W-1:0] out_tid;
    logic [1:0]       mode_o;
    logic             err_o;

    exp_t       exp_q  [N][$];
    exp_t       pend_q [N][$];
    logic [1:0] hist [$];
    int         last_issue [N];
    int         tests;
    int         fails;
    int         j;
    logic [TID_W-1:0] exp_tid;

    preadd_issue #(
        .DEPTH (DEPTH),
        .TID_W (TID_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tid    (in_tid),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .x_o       (x_o),
        .y_o       (y_o),
        .out_valid (out_valid),
        .out_tid   (out_tid),
        .mode_o    (mode_o),
        .err_o     (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: expected slot owner, payload, bubble zeros and delayed mode each cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] m;
        if (rst) begin
            j       = 0;
            exp_tid = '0;
            hist.delete();
            for (int i = 0; i < N; i++) hist.push_back(MODE_BUBBLE);
        end else begin
            checkOutput("out_tid", 64'(out_tid), 64'(exp_tid));
            m = MODE_BUBBLE;
            if (out_valid) begin
                if (exp_q[exp_tid].size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_issue: got x_o=%0h on tid %0d, expected bubble", x_o, exp_tid);
                end else begin
                    e = exp_q[exp_tid].pop_front();
                    checkOutput("x_o", 64'(x_o), 64'(e.x));
                    checkOutput("y_o", 64'(y_o), 64'(e.y));
                    if (!e.first) checkOutput("issue_gap", 64'(j - last_issue[exp_tid]), 64'(N));
                    last_issue[exp_tid] = j;
                    m = e.mode;
                end
            end else begin
                checkOutput("bubble_x", 64'(x_o), 64'd0);
                checkOutput("bubble_y", 64'(y_o), 64'd0);
            end
            hist.push_back(m);
            checkOutput("mode_o", 64'(mode_o), 64'(hist.pop_front()));
            exp_tid = (j == 0) ? '0 : TID_W'((32'(exp_tid) + 1) % N);
            j++;
        end
    end

    task automatic resetDut();
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int t = 0; t < N; t++) begin
            exp_q[t].delete();
            pend_q[t].delete();
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one operand; on accept, record it and release the chain on its last entry.
    task automatic applyStimulus(input int tid, input int xv, input int yv,
                                 input logic [1:0] mode, input logic last);
        int   waited;
        exp_t e;
        in_valid = 1'b1;
        in_tid   = TID_W'(tid);
        in_x     = POLY_W'(xv);
        in_y     = POLY_W'(yv);
        in_mode  = mode;
        in_last  = last;
        waited   = 0;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL send_timeout: got in_ready=0 for tid %0d, expected 1", tid);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (mode_legal(mode)) begin
            e.x     = POLY_W'(xv);
            e.y     = POLY_W'(yv);
            e.mode  = mode;
            e.first = (pend_q[tid].size() == 0);
            pend_q[tid].push_back(e);
            if (last) begin
                while (pend_q[tid].size() > 0) exp_q[tid].push_back(pend_q[tid].pop_front());
            end
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_tid   = '0;
        in_x     = '0;
        in_y     = '0;
        in_mode  = MODE_BUBBLE;
        in_last  = 1'b0;
        resetDut();

        // Single chain on thread 2.
        applyStimulus(2, 'h0A, 'h1A, MODE_ADD, 1'b0);
        applyStimulus(2, 'h0B, 'h1B, MODE_SUB, 1'b0);
        applyStimulus(2, 'h0C, 'h1C, MODE_ADD, 1'b1);
        idleCycles(30);

        // Incomplete chain on thread 1 must stay parked until its last entry.
        applyStimulus(1, 'h2A, 'h3A, MODE_SUB, 1'b0);
        applyStimulus(1, 'h2B, 'h3B, MODE_SUB, 1'b0);
        idleCycles(20);
        applyStimulus(1, 'h2C, 'h3C, MODE_ADD, 1'b1);
        idleCycles(30);

        // Two chains of three on every thread.
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 3; p++)
                for (int t = 0; t < N; t++)
                    applyStimulus(t, 'h1000 + t*256 + c*16 + p, 'h2000 + t*256 + c*16 + p,
                                  ((p + t) % 2 == 0) ? MODE_ADD : MODE_SUB, p == 2);
        idleCycles(60);

        // Fill thread 0 completely, then a 9th offer is refused while thread 3 is accepted.
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(0, 'h300 + k, 'h400 + k, (k % 2 == 0) ? MODE_SUB : MODE_ADD, k == DEPTH - 1);
        in_valid = 1'b1;
        in_tid   = TID_W'(0);
        #1 checkOutput("in_ready_full", 64'(in_ready), 64'd0);
        in_tid = TID_W'(3);
        #1 checkOutput("in_ready_other", 64'(in_ready), 64'd1);
        applyStimulus(3, 'h500, 'h600, MODE_ADD, 1'b1);
        idleCycles(60);
        checkOutput("err_clean", 64'(err_o), 64'd0);

        // Reset while chains are in flight.
        applyStimulus(0, 'h700, 'h800, MODE_ADD, 1'b0);
        applyStimulus(2, 'h701, 'h801, MODE_SUB, 1'b0);
        applyStimulus(0, 'h702, 'h802, MODE_ADD, 1'b1);
        applyStimulus(2, 'h703, 'h803, MODE_SUB, 1'b1);
        idleCycles(3);
        rst = 1'b1;
        #1;
        checkOutput("rst_x_o", 64'(x_o), 64'd0);
        checkOutput("rst_y_o", 64'(y_o), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_tid", 64'(out_tid), 64'd0);
        checkOutput("rst_mode", 64'(mode_o), 64'd0);
        resetDut();
        checkOutput("rst_err", 64'(err_o), 64'd0);
        idleCycles(20);

        // Illegal mode is accepted, flagged and never issued.
        applyStimulus(1, 'hBAD, 'hBAD, 2'b11, 1'b1);
        checkOutput("err_illegal", 64'(err_o), 64'd1);
        idleCycles(20);
        resetDut();

        // Chain overflow: a full thread without a last entry freezes and flags.
        for (int k = 0; k < DEPTH; k++)
            applyStimulus(1, 'h900 + k, 'hA00 + k, MODE_ADD, 1'b0);
        idleCycles(2);
        checkOutput("err_overflow", 64'(err_o), 64'd1);
        in_valid = 1'b1;
        in_tid   = TID_W'(1);
        in_last  = 1'b1;
        #1 checkOutput("in_ready_frozen", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        idleCycles(40);
        applyStimulus(2, 'hB00, 'hC00, MODE_SUB, 1'b0);
        applyStimulus(2, 'hB01, 'hC01, MODE_ADD, 1'b1);
        idleCycles(20);

        for (int t = 0; t < N; t++)
            checkOutput($sformatf("drain_t%0d", t), 64'(exp_q[t].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/preadd_issue.md
# preadd_issue

Thread-interleaved operand issuer sitting directly upstream of the N-thread pre-adder. It buffers operand pairs per thread and emits them on a fixed round-robin slot schedule, so consecutive operands of one thread arrive exactly N_THREADS cycles apart, as the pre-adder's delay lines require. It only releases a thread's operand chain once the whole chain is buffered. It generates the mode stream delayed by N_THREADS cycles, aligned to the pre-adder's output mux.

## Interface
- N_THREADS, package constant (PARAMS_BN254_d0): number of interleaved threads and slots per round; ≥2.
- DEPTH, 8: entries per thread queue; power of two.
- TID_W, $clog2(N_THREADS): thread-id width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  operand accepted when in_valid&in_ready.
- in_tid  in  TID_W  target thread.
- in_x, in_y  in  redundant_poly_L3  operands.
- in_mode  in  2  pre-adder mode; only 2'b01 / 2'b10 legal.
- in_last  in  1  final operand of a chain.
- x_o, y_o  out  redundant_poly_L3  to pre-adder X, Y.
- out_valid  out  1  x_o/y_o carry a real operand (0 = bubble).
- out_tid  out  TID_W  slot owner of current x_o/y_o.
- mode_o  out  2  to pre-adder mode.
- err_o  out  1  sticky protocol error.

## Operation
- Slot counter s: 0..N_THREADS-1, +1 every cycle, wraps to 0.
- Per-thread FIFO of DEPTH entries {x, y, mode, last}, plus count[t] and grp[t] (complete chains held).
- in_ready = count[in_tid] < DEPTH, from registered state only. No bypass from enqueue to issue.
- Issue decision in slot s: pop head of thread s iff grp[s] > 0. Otherwise issue a bubble (x_o=y_o=0, out_valid=0, recorded mode 2'b00).
- Issued chains therefore stream one entry per turn of that thread, without gaps, until the entry with last=1.
- grp[t]: +1 on accept of last=1, −1 on issue of last=1, unchanged if both happen in one cycle.
- count[t]: +1 on accept, −1 on issue, unchanged if both happen.
- Illegal in_mode (00/11): entry is accepted (in_ready as normal) then dropped, and err_o is set.
- Chain overflow: thread full with grp[t]=0 sets err_o. The queue is then frozen until reset.
- mode_o: shift register of N_THREADS stages, fed with the mode of each issued entry (00 for bubbles).

## Timing
- Reset, async assert: slot=0, all counts/grp=0, x_o=y_o=0, out_valid=0, out_tid=0, mode_o=00, err_o=0, mode shift register cleared.
- First slot after reset deassertion is 0.
- Accept at cycle c → earliest x_o at c+2, with the decision in the first cycle ≥ c+1 where s==tid.
- x_o/y_o/out_valid/out_tid are registered and valid the cycle after the decision. out_tid = slot of that decision.
- mode_o at cycle c+N_THREADS = mode of the entry presented on x_o at cycle c.
- Reset mid-chain drops all buffered and in-flight data. There is no partial output after reset.
- err_o clears only on rst.

## Structure
- Add to PARAMS_BN254_d0: typedef preadd_op_t {redundant_poly_L3 x, y; logic [1:0] mode; logic last}.
- Per-thread queue as sub-module preadd_thread_fifo (DEPTH-entry circular buffer with count), instantiated N_THREADS times via generate.
- Slot counter, grp counters, mode shift register and output registers live in the top.

## Test plan
- Reset mid-stream: assert rst with chains queued → all outputs 0 immediately; after release, slot 0 bubble and err_o=0.
- N_THREADS=4, single chain on thread 2 (x=A,B,C; last on C) → x_o=A,B,C at cycles 4 apart, out_tid=2; mode_o matches each entry 4 cycles after its x_o.
- Incomplete chain: thread 1 gets A,B (last=0), waits 20 cycles, then C (last=1) → no issue before C is accepted, then A,B,C on consecutive turns of thread 1.
- All four threads, 2 chains each of length 3 → every slot out_valid=1 until drained, out_tid=0,1,2,3 repeating, per-thread order preserved.
- Full queue: DEPTH=8 entries on thread 0 with last on entry 8 → in_ready low for tid 0 on the 9th offer; simultaneous accept on thread 3 still succeeds.
- Error cases: in_mode=2'b11 → err_o=1 next cycle and entry never issued. 8 entries without last → err_o=1 and thread queue frozen.
